// File: rtl/imem_arbiter.sv
// Two-port arbiter sharing the imem request/response channel. Responses are routed back through an in-order owner FIFO.
// Zero-latency pass-through; per-port flush drops in-flight responses. Round-robin when IMEM_ARB_RR_EN is defined, else port 0 priority.
module imem_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic [31:0] m0_req_addr,
    output logic        m0_resp_valid,
    input  logic        m0_resp_ready,
    output logic [31:0] m0_resp_inst,
    input  logic        m0_flush,
    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic [31:0] m1_req_addr,
    output logic        m1_resp_valid,
    input  logic        m1_resp_ready,
    output logic [31:0] m1_resp_inst,
    input  logic        m1_flush,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    output logic        imem_resp_ready,
    input  logic [31:0] imem_resp_inst
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(MAX_OUTSTANDING);

    logic [CW-1:0]              count_q;
    logic [PW-1:0]              wr_ptr_q;
    logic [PW-1:0]              rd_ptr_q;
    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [MAX_OUTSTANDING-1:0] drop_q;
    logic [MAX_OUTSTANDING-1:0] vld_q;
    logic                       lock_q;
    logic                       lock_grant_q;
    logic                       grant;
    logic                       full;
    logic                       req_fire;
    logic                       resp_fire;
    logic                       nonempty;
    logic                       head_owner;
    logic                       head_drop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

`ifdef IMEM_ARB_RR_EN
    logic last_grant_q;

    always_comb begin
        grant = !m0_req_valid;
        if (lock_q)
            grant = lock_grant_q;
        else if (m0_req_valid && m1_req_valid)
            grant = !last_grant_q;
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_grant_q <= 1'b1;
        else if (req_fire)
            last_grant_q <= grant;
    end
`else
    always_comb begin
        grant = lock_q ? lock_grant_q : !m0_req_valid;
    end
`endif

    assign full           = (count_q == CNT_FULL);
    assign imem_req_valid = !full && (m0_req_valid || m1_req_valid);
    assign imem_req_addr  = grant ? m1_req_addr : m0_req_addr;
    assign m0_req_ready   = !grant && imem_req_valid && imem_req_ready;
    assign m1_req_ready   =  grant && imem_req_valid && imem_req_ready;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A flush for the head's owner drops it this cycle, before the registered drop bit catches up.
    assign nonempty        = (count_q != '0);
    assign head_owner      = owner_q[rd_ptr_q];
    assign head_drop       = drop_q[rd_ptr_q] || (head_owner ? m1_flush : m0_flush);
    assign imem_resp_ready = nonempty && (head_drop || (head_owner ? m1_resp_ready : m0_resp_ready));
    assign m0_resp_valid   = nonempty && !head_drop && !head_owner && imem_resp_valid;
    assign m1_resp_valid   = nonempty && !head_drop &&  head_owner && imem_resp_valid;
    assign m0_resp_inst    = imem_resp_inst;
    assign m1_resp_inst    = imem_resp_inst;
    assign resp_fire       = imem_resp_valid && imem_resp_ready;

    // The grant is frozen while a presented request waits, keeping addr stable until it fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q       <= 1'b0;
            lock_grant_q <= 1'b0;
        end else if (req_fire) begin
            lock_q <= 1'b0;
        end else if (imem_req_valid) begin
            lock_q       <= 1'b1;
            lock_grant_q <= grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            owner_q  <= '0;
            drop_q   <= '0;
            vld_q    <= '0;
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (vld_q[i] && (owner_q[i] ? m1_flush : m0_flush))
                    drop_q[i] <= 1'b1;
            end
            if (resp_fire) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= ptr_next(rd_ptr_q);
            end
            // A request fired in its own port's flush cycle is live, so push wins over flush marking.
            if (req_fire) begin
                owner_q[wr_ptr_q] <= grant;
                drop_q[wr_ptr_q]  <= 1'b0;
                vld_q[wr_ptr_q]   <= 1'b1;
                wr_ptr_q          <= ptr_next(wr_ptr_q);
            end
            if (req_fire && !resp_fire)
                count_q <= count_q + CW'(1);
            else if (!req_fire && resp_fire)
                count_q <= count_q - CW'(1);
        end
    end

    resp_without_request: assert property (@(posedge clk) disable iff (rst) !(imem_resp_valid && !nonempty));
endmodule
